// File: rtl/gpu_fill_sequencer.sv
// gpu_fill_sequencer
//   Rectangle-fill controller for the GPU-to-SRAM write port. Accepts one
//   rectangle command at a time, clips it to the H_RES x V_RES frame and
//   emits one pixel write per cycle, only while the display is in blanking.
//
// Optional feature:
//   GPU_FILL_CHECKER_EN - when defined, pixels with odd (x+y) are written
//   with the bitwise-inverted colour (1-pixel checkerboard). Address order,
//   timing and write count are unchanged.
//
// Ports:
//   I_CLK, I_RST        clock; synchronous active-high reset
//   I_VIDEO_ON          1 = active scan (writes stalled), 0 = blanking
//   I_CMD_VALID/O_CMD_READY   command handshake
//   I_CMD_X0/Y0/X1/Y1   inclusive rectangle corners
//   I_CMD_COLOR         fill colour in SRAM pixel format
//   O_GPU_ADDR/DATA     registered SRAM word address / write data
//   O_GPU_WRITE         write strobe, one word per high cycle
//   O_GPU_READ          read strobe, always 0
//   O_BUSY              command accepted and not yet finished
//   O_DONE              one-cycle completion pulse
module gpu_fill_sequencer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 400,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_VIDEO_ON,
    input  logic              I_CMD_VALID,
    output logic              O_CMD_READY,
    input  logic [9:0]        I_CMD_X0,
    input  logic [9:0]        I_CMD_Y0,
    input  logic [9:0]        I_CMD_X1,
    input  logic [9:0]        I_CMD_Y1,
    input  logic [DATA_W-1:0] I_CMD_COLOR,
    output logic [ADDR_W-1:0] O_GPU_ADDR,
    output logic [DATA_W-1:0] O_GPU_DATA,
    output logic              O_GPU_WRITE,
    output logic              O_GPU_READ,
    output logic              O_BUSY,
    output logic              O_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLIP,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam logic [9:0]        X_MAX  = 10'(H_RES - 1);
    localparam logic [9:0]        Y_MAX  = 10'(V_RES - 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

    state_t              state_q, state_n;
    logic [9:0]          x0_q, y0_q, x1_q, y1_q;
    logic [9:0]          x0_n, y0_n, x1_n, y1_n;
    logic [9:0]          x_q, y_q, x_n, y_n;
    logic [ADDR_W-1:0]   row_base_q, row_base_n;
    logic [DATA_W-1:0]   color_q, color_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic                write_q, write_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                ready_q, ready_n;

    logic [9:0]          x1_clamp, y1_clamp;
    logic                cmd_empty;
    logic                last_pixel;
    logic [DATA_W-1:0]   pixel_data;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            color_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_n;
            x0_q       <= x0_n;
            y0_q       <= y0_n;
            x1_q       <= x1_n;
            y1_q       <= y1_n;
            x_q        <= x_n;
            y_q        <= y_n;
            row_base_q <= row_base_n;
            color_q    <= color_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
            write_q    <= write_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            ready_q    <= ready_n;
        end
    end

    always_comb begin
        x1_clamp   = (x1_q > X_MAX) ? X_MAX : x1_q;
        y1_clamp   = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        cmd_empty  = (x0_q > X_MAX) || (y0_q > Y_MAX) ||
                     (x0_q > x1_clamp) || (y0_q > y1_clamp);
        last_pixel = (x_q == x1_q) && (y_q == y1_q);
`ifdef GPU_FILL_CHECKER_EN
        pixel_data = (x_q[0] ^ y_q[0]) ? ~color_q : color_q;
`else
        pixel_data = color_q;
`endif
    end

    always_comb begin
        state_n    = state_q;
        x0_n       = x0_q;
        y0_n       = y0_q;
        x1_n       = x1_q;
        y1_n       = y1_q;
        x_n        = x_q;
        y_n        = y_q;
        row_base_n = row_base_q;
        color_n    = color_q;
        addr_n     = addr_q;
        data_n     = data_q;
        write_n    = 1'b0;
        busy_n     = busy_q;
        done_n     = 1'b0;
        ready_n    = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (ready_q && I_CMD_VALID) begin
                    x0_n    = I_CMD_X0;
                    y0_n    = I_CMD_Y0;
                    x1_n    = I_CMD_X1;
                    y1_n    = I_CMD_Y1;
                    color_n = I_CMD_COLOR;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
                    state_n = ST_CLIP;
                end else begin
                    // First IDLE cycle after DONE still shows O_DONE with
                    // ready low; the handshake reopens on the following edge.
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end

            ST_CLIP: begin
                if (cmd_empty) begin
                    state_n = ST_DONE;
                end else begin
                    x1_n       = x1_clamp;
                    y1_n       = y1_clamp;
                    x_n        = x0_q;
                    y_n        = y0_q;
                    row_base_n = ADDR_W'(y0_q) * STRIDE;
                    state_n    = ST_FILL;
                end
            end

            ST_FILL: begin
                // Active scan holds every counter; only blanking cycles write.
                if (!I_VIDEO_ON) begin
                    write_n = 1'b1;
                    addr_n  = row_base_q + ADDR_W'(x_q);
                    data_n  = pixel_data;
                    if (last_pixel) begin
                        state_n = ST_DONE;
                    end else if (x_q < x1_q) begin
                        x_n = x_q + 10'd1;
                    end else begin
                        x_n        = x0_q;
                        y_n        = y_q + 10'd1;
                        row_base_n = row_base_q + STRIDE;
                    end
                end
            end

            ST_DONE: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign O_CMD_READY = ready_q;
    assign O_GPU_ADDR  = addr_q;
    assign O_GPU_DATA  = data_q;
    assign O_GPU_WRITE = write_q;
    assign O_GPU_READ  = 1'b0;
    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;

endmodule

// File: tb/tb_gpu_fill_sequencer.sv
// tb_gpu_fill_sequencer
//   Self-checking bench for gpu_fill_sequencer: reset values, a table of
//   directed rectangles, hand-written reset-mid-fill sequence and randomized
//   rectangles with random blanking, all checked against a pixel-list model.
module tb_gpu_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vo;
    logic        valid;
    logic        ready;
    logic [9:0]  cx0, cy0, cx1, cy1;
    logic [15:0] color;
    logic [17:0] gaddr;
    logic [15:0] gdata;
    logic        gwrite, gread, busy, done;

    always #5 clk = ~clk;

    gpu_fill_sequencer #(.H_RES(640), .V_RES(400), .ADDR_W(18), .DATA_W(16)) dut (
        .I_CLK       (clk),
        .I_RST       (rst),
        .I_VIDEO_ON  (vo),
        .I_CMD_VALID (valid),
        .O_CMD_READY (ready),
        .I_CMD_X0    (cx0),
        .I_CMD_Y0    (cy0),
        .I_CMD_X1    (cx1),
        .I_CMD_Y1    (cy1),
        .I_CMD_COLOR (color),
        .O_GPU_ADDR  (gaddr),
        .O_GPU_DATA  (gdata),
        .O_GPU_WRITE (gwrite),
        .O_GPU_READ  (gread),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [17:0] exp_a[$];
    logic [15:0] exp_d[$];

    typedef struct {
        logic [9:0]  x0, y0, x1, y1;
        logic [15:0] col;
        int          mode;   // 0 = always blanking, 1 = random, 2 = 5-cycle stall after 2nd write
        int          n;
        logic [17:0] fa, la;
        logic [15:0] ld;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] alt(input logic [15:0] c);
`ifdef GPU_FILL_CHECKER_EN
        return ~c;
`else
        return c;
`endif
    endfunction

    // Expected pixel list: clipped rectangle, row-major, address = y*640+x.
    task automatic model(input int x0, input int y0, input int x1, input int y1,
                         input logic [15:0] c);
        exp_a.delete();
        exp_d.delete();
        if (x1 > 639) x1 = 639;
        if (y1 > 399) y1 = 399;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                exp_a.push_back(18'(y * 640 + x));
                exp_d.push_back(((x + y) % 2 == 1) ? alt(c) : c);
            end
    endtask

    task automatic run_cmd(input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1,
                           input logic [15:0] col, input int mode,
                           output int nwr, output logic [17:0] fa,
                           output logic [17:0] la, output logic [15:0] ld);
        int t;
        int to;
        int stall;
        int total;
        int wt[$];
        bit got_done;
        model(int'(x0), int'(y0), int'(x1), int'(y1), col);
        total = exp_a.size();
        nwr = 0; fa = '0; la = '0; ld = '0;
        to = 0;
        while (ready !== 1'b1 && to < 100) begin
            @(posedge clk); #1; to++;
        end
        chk("ready_before_cmd", ready, 1);
        valid = 1'b1; cx0 = x0; cy0 = y0; cx1 = x1; cy1 = y1; color = col;
        vo = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        chk("busy_after_accept", busy, 1);
        chk("ready_low_after_accept", ready, 0);
        t = 0; stall = 0; got_done = 0;
        while (!got_done && t < 3000) begin
            // Junk on the command bus while busy must be ignored.
            valid = 1'($urandom_range(0, 1));
            cx0 = 10'($urandom); cy0 = 10'($urandom);
            cx1 = 10'($urandom); cy1 = 10'($urandom);
            color = 16'($urandom);
            case (mode)
                1:       vo = 1'($urandom_range(0, 1));
                2:       vo = (stall > 0);
                default: vo = 1'b0;
            endcase
            @(posedge clk);
            if (stall > 0) stall--;
            #1; t++;
            if (gwrite) begin
                if (nwr >= total) begin
                    chk("extra_write", nwr + 1, total);
                end else begin
                    chk("addr", gaddr, exp_a.pop_front());
                    chk("data", gdata, exp_d.pop_front());
                end
                if (nwr == 0) fa = gaddr;
                la = gaddr; ld = gdata;
                wt.push_back(t);
                nwr++;
                if (mode == 2 && nwr == 2) stall = 5;
            end
            if (done) got_done = 1;
        end
        valid = 1'b0;
        if (!got_done) begin
            chk("done_timeout", t, 0);
        end else begin
            chk("write_low_at_done", gwrite, 0);
            chk("write_count", nwr, total);
            if (nwr > 0) chk("done_after_last_write", t, wt[wt.size() - 1] + 1);
            else         chk("empty_done_latency", t, 2);
            if (mode == 0 && nwr > 0) begin
                chk("first_write_latency", wt[0], 2);
                chk("writes_back_to_back", wt[nwr - 1] - wt[0], nwr - 1);
            end
            if (mode == 2 && nwr >= 3) chk("stall_gap", wt[2] - wt[1], 6);
            vo = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("done_one_cycle", done, 0);
            chk("ready_after_done", ready, 1);
            chk("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          nwr;
        int          cnt;
        int          to;
        int          rx0, ry0, rx1, ry1;
        logic [17:0] fa, la;
        logic [15:0] ld;

        tbl[0] = '{10'd0,   10'd0,   10'd1,   10'd1,   16'hF00F, 0, 4,   18'd0,      18'd641,    16'hF00F};
        tbl[1] = '{10'd10,  10'd2,   10'd13,  10'd2,   16'hA5A5, 2, 4,   18'd1290,   18'd1293,   alt(16'hA5A5)};
        tbl[2] = '{10'd638, 10'd399, 10'd700, 10'd500, 16'h7E7E, 0, 2,   18'd255998, 18'd255999, 16'h7E7E};
        tbl[3] = '{10'd5,   10'd0,   10'd4,   10'd0,   16'h1111, 0, 0,   18'd0,      18'd0,      16'h0};
        tbl[4] = '{10'd640, 10'd0,   10'd645, 10'd3,   16'h2222, 0, 0,   18'd0,      18'd0,      16'h0};
        tbl[5] = '{10'd0,   10'd400, 10'd3,   10'd410, 16'h3333, 0, 0,   18'd0,      18'd0,      16'h0};
        tbl[6] = '{10'd0,   10'd0,   10'd1,   10'd0,   16'h1234, 0, 2,   18'd0,      18'd1,      alt(16'h1234)};
        tbl[7] = '{10'd0,   10'd0,   10'd639, 10'd0,   16'h0F0F, 0, 640, 18'd0,      18'd639,    alt(16'h0F0F)};
        tbl[8] = '{10'd639, 10'd399, 10'd639, 10'd399, 16'hBEEF, 1, 1,   18'd255999, 18'd255999, 16'hBEEF};

        rst = 1'b1; vo = 1'b0; valid = 1'b0;
        cx0 = '0; cy0 = '0; cx1 = '0; cy1 = '0; color = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_write", gwrite, 0);
        chk("reset_read", gread, 0);
        chk("reset_addr", gaddr, 0);
        chk("reset_data", gdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].col,
                    tbl[i].mode, nwr, fa, la, ld);
            chk($sformatf("vec%0d_count", i), nwr, tbl[i].n);
            if (tbl[i].n > 0) begin
                chk($sformatf("vec%0d_first_addr", i), fa, tbl[i].fa);
                chk($sformatf("vec%0d_last_addr", i), la, tbl[i].la);
                chk($sformatf("vec%0d_last_data", i), ld, tbl[i].ld);
            end
        end

        // Reset in the middle of a 10x10 fill.
        valid = 1'b1; vo = 1'b0;
        cx0 = 10'd0; cy0 = 10'd0; cx1 = 10'd9; cy1 = 10'd9; color = 16'h5A5A;
        @(posedge clk); #1;
        valid = 1'b0;
        cnt = 0; to = 0;
        while (cnt < 13 && to < 200) begin
            @(posedge clk); #1; to++;
            if (gwrite) cnt++;
        end
        chk("writes_before_reset", cnt, 13);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_write", gwrite, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_write_after_reset", gwrite, 0);
        end
        run_cmd(10'd3, 10'd3, 10'd3, 10'd3, 16'hC0DE, 0, nwr, fa, la, ld);
        chk("post_reset_count", nwr, 1);
        chk("post_reset_addr", fa, 1923);

        for (int i = 0; i < 40; i++) begin
            rx0 = $urandom_range(0, 650);
            ry0 = $urandom_range(0, 405);
            rx1 = rx0 + $urandom_range(0, 6) - (($urandom_range(0, 9) == 0) ? 8 : 0);
            ry1 = ry0 + $urandom_range(0, 5) - (($urandom_range(0, 9) == 0) ? 7 : 0);
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            run_cmd(10'(rx0), 10'(ry0), 10'(rx1), 10'(ry1), 16'($urandom),
                    (i % 4 == 0) ? 0 : 1, nwr, fa, la, ld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
